// File: rtl/dmem_responder.sv
// Handshaked data-memory responder: one word/halfword load or store at a time,
// LATENCY cycles of wait states, response held until accepted.
// Optional build macro DMEM_RANGE_CHECK_EN flags accesses beyond the storage depth.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_half,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_we;
  logic                r_half;
  logic                r_hsel;
  logic                r_oor;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_wdata;
  logic [31:0]         r_mem [DEPTH];

  logic                w_oor_c;
  logic                w_unused_addr;
  logic                w_commit;
  logic                w_mem_we;
  logic [31:0]         w_word;
  logic [31:0]         w_wr_word;
  logic [31:0]         w_rd_data;

`ifdef DMEM_RANGE_CHECK_EN
  assign w_oor_c       = |req_addr[31:ADDR_W+2];
  assign w_unused_addr = req_addr[0];
`else
  assign w_oor_c       = 1'b0;
  assign w_unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[0]};
`endif

  // Access happens on the last wait cycle; the FSM is in IDLE while reset is held.
  assign w_commit  = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_mem_we  = w_commit && r_we && !r_oor;
  assign w_word    = r_mem[r_idx];

  assign w_wr_word = !r_half ? r_wdata :
                     r_hsel  ? {r_wdata[15:0], w_word[15:0]} :
                               {w_word[31:16], r_wdata[15:0]};

  assign w_rd_data = (r_we || r_oor) ? 32'h0 :
                     !r_half         ? w_word :
                     r_hsel          ? {16'h0, w_word[31:16]} :
                                       {16'h0, w_word[15:0]};

  // Storage has no reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_half    <= 1'b0;
      r_hsel    <= 1'b0;
      r_oor     <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_half    <= req_half;
            r_hsel    <= req_addr[1];
            r_oor     <= w_oor_c;
            r_idx     <= req_addr[ADDR_W+1:2];
            r_wdata   <= req_wdata;
            r_cnt     <= CNT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= w_rd_data;
            rsp_err   <= r_oor;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// against a word-array reference model.
module tb_dmem_responder;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LAT    = 2;
  localparam int unsigned PERIOD = 10;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_half;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] m_mem [DEPTH];

  always #(PERIOD / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_half  (req_half),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Reference model: byte address -> word index by division, halves by masks.
  function automatic void model(input logic we, input logic half, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output logic err);
    int   idx;
    logic oor;
`ifdef DMEM_RANGE_CHECK_EN
    oor = (addr / (32'd4 * DEPTH)) != 32'd0;
`else
    oor = 1'b0;
`endif
    idx = int'((addr / 32'd4) % DEPTH);
    rd  = 32'h0;
    err = oor;
    if (we) begin
      if (!oor) begin
        if (!half)
          m_mem[idx] = wdata;
        else if (addr[1])
          m_mem[idx] = (m_mem[idx] & 32'h0000FFFF) | ({16'h0, wdata[15:0]} << 16);
        else
          m_mem[idx] = (m_mem[idx] & 32'hFFFF0000) | {16'h0, wdata[15:0]};
      end
    end else if (!oor) begin
      if (!half)        rd = m_mem[idx];
      else if (addr[1]) rd = m_mem[idx] >> 16;
      else              rd = m_mem[idx] & 32'h0000FFFF;
    end
  endfunction

  // One full transaction; returns observed data, error and accept-to-valid cycles.
  task automatic send(input logic we, input logic half, input logic [31:0] addr,
                      input logic [31:0] wdata, input int stall,
                      output logic [31:0] rd, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_half = half; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_assert++; n_fail++;
      $display("FAIL send_accept_timeout: req_ready=%0b required 1", req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_half = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    rd  = rsp_rdata;
    err = rsp_err;
    repeat (stall) @(posedge clk);
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_half = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_assert++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %0b want 1", req_ready); end
    n_assert++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    n_assert++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    n_assert++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %0b want 0", rsp_err); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd, v;
    logic        err, eerr;
    int          lat;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom;
      model(1'b1, 1'b0, 32'(i * 4), v, erd, eerr);
      send(1'b1, 1'b0, 32'(i * 4), v, 0, rd, err, lat);
      n_assert++;
      if (rd !== erd || err !== eerr || lat != int'(LAT)) begin
        n_fail++;
        $display("FAIL fill_store[%0d]: rdata=%h err=%0b lat=%0d want rdata=%h err=%0b lat=%0d",
                 i, rd, err, lat, erd, eerr, LAT);
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;
    model(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, erd, eerr);
    send(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, err, lat);
    n_assert++;
    if (rd !== 32'h0 || lat != int'(LAT)) begin
      n_fail++; $display("FAIL word_store: rdata=%h lat=%0d want rdata=0 lat=%0d", rd, lat, LAT);
    end
    send(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, err, lat);
    n_assert++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || lat != int'(LAT)) begin
      n_fail++; $display("FAIL word_load: rdata=%h err=%0b lat=%0d want rdata=deadbeef err=0 lat=%0d",
                         rd, err, lat, LAT);
    end
  endtask

  task automatic test_halfword();
    logic [31:0] t_addr [8] = '{32'h20, 32'h22, 32'h20, 32'h20, 32'h22, 32'h23, 32'h21, 32'h22};
    logic [31:0] t_wd   [8] = '{32'h11223344, 32'h5A5AABCD, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] t_exp  [8] = '{32'h0, 32'h0, 32'hABCD3344, 32'h00003344, 32'h0000ABCD,
                                32'h0000ABCD, 32'h00003344, 32'hABCD3344};
    logic [7:0]  t_we   = 8'b00000011;
    logic [7:0]  t_half = 8'b01111010;
    logic [31:0] rd, erd;
    logic        err, eerr;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      model(t_we[i], t_half[i], t_addr[i], t_wd[i], erd, eerr);
      send(t_we[i], t_half[i], t_addr[i], t_wd[i], 0, rd, err, lat);
      n_assert++;
      if (rd !== t_exp[i] || err !== 1'b0 || lat != int'(LAT)) begin
        n_fail++;
        $display("FAIL halfword[%0d]: rdata=%h err=%0b lat=%0d want rdata=%h err=0 lat=%0d",
                 i, rd, err, lat, t_exp[i], LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd, v2;
    logic        err, eerr;
    int          lat, n;
    model(1'b0, 1'b0, 32'h20, 32'h0, erd, eerr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_half = 1'b0; req_addr = 32'h20; req_wdata = '0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    n_assert++;
    if (rsp_rdata !== erd || lat != int'(LAT)) begin
      n_fail++; $display("FAIL bp_first: rdata=%h lat=%0d want rdata=%h lat=%0d", rsp_rdata, lat, erd, LAT);
    end
    v2 = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b0; req_addr = 32'h10; req_wdata = v2;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_assert++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== erd || req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: rsp_valid=%0b rdata=%h req_ready=%0b want 1 %h 0",
                 c, rsp_valid, rsp_rdata, req_ready, erd);
      end
    end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_assert++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: rsp_valid=%0b req_ready=%0b want 0 1", rsp_valid, req_ready);
    end
    rsp_ready = 1'b0;
    model(1'b1, 1'b0, 32'h10, v2, erd, eerr);
    @(posedge clk); #1;
    n_assert++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_next_accept: req_ready=%0b want 0", req_ready);
    end
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    @(negedge clk) rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    send(1'b0, 1'b0, 32'h10, 32'h0, 0, rd, err, lat);
    n_assert++;
    if (rd !== v2) begin
      n_fail++; $display("FAIL bp_store_landed: rdata=%h want %h", rd, v2);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd, eold;
    logic        err, eerr;
    int          lat, n;
    model(1'b0, 1'b0, 32'h30, 32'h0, eold, eerr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b0; req_addr = 32'h30; req_wdata = 32'h55;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk) reset = 1'b0;
    #1;
    n_assert++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: req_ready=%0b rsp_valid=%0b rdata=%h err=%0b want 1 0 0 0",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    send(1'b0, 1'b0, 32'h30, 32'h0, 0, rd, err, lat);
    n_assert++;
    if (rd !== eold) begin
      n_fail++; $display("FAIL midreset_dropped_store: rdata=%h want %h", rd, eold);
    end
    model(1'b1, 1'b0, 32'h34, 32'h77, erd, eerr);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_half = 1'b0; req_addr = 32'h34; req_wdata = 32'h77;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    @(negedge clk) reset = 1'b0;
    #1;
    n_assert++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL resp_discard: rsp_valid=%0b req_ready=%0b want 0 1", rsp_valid, req_ready);
    end
    @(negedge clk) reset = 1'b1;
    send(1'b0, 1'b0, 32'h34, 32'h0, 0, rd, err, lat);
    model(1'b0, 1'b0, 32'h34, 32'h0, erd, eerr);
    n_assert++;
    if (rd !== erd) begin
      n_fail++; $display("FAIL committed_store_kept: rdata=%h want %h", rd, erd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd, erd, v;
    logic        err, eerr;
    int          lat;
    v = $urandom;
    model(1'b1, 1'b0, 32'h400, v, erd, eerr);
    send(1'b1, 1'b0, 32'h400, v, 0, rd, err, lat);
    n_assert++;
    if (err !== eerr || rd !== 32'h0 || lat != int'(LAT)) begin
      n_fail++; $display("FAIL range_store: err=%0b rdata=%h lat=%0d want err=%0b rdata=0 lat=%0d",
                         err, rd, lat, eerr, LAT);
    end
    model(1'b0, 1'b0, 32'h0, 32'h0, erd, eerr);
    send(1'b0, 1'b0, 32'h0, 32'h0, 0, rd, err, lat);
    n_assert++;
    if (rd !== erd || err !== 1'b0) begin
      n_fail++; $display("FAIL range_word0: rdata=%h err=%0b want %h 0", rd, err, erd);
    end
    model(1'b0, 1'b0, 32'h8000_0404, 32'h0, erd, eerr);
    send(1'b0, 1'b0, 32'h8000_0404, 32'h0, 0, rd, err, lat);
    n_assert++;
    if (rd !== erd || err !== eerr) begin
      n_fail++; $display("FAIL range_load: rdata=%h err=%0b want %h %0b", rd, err, erd, eerr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] t_addr [3] = '{32'h10, 32'h20, 32'h30};
    logic [31:0] erd [3];
    logic        eerr;
    int          acc [3];
    int          lat, n;
    for (int k = 0; k < 3; k++) model(1'b0, 1'b0, t_addr[k], 32'h0, erd[k], eerr);
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_half = 1'b0; req_addr = t_addr[0]; req_wdata = '0;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      acc[k] = cyc;
      if (k < 2) req_addr = t_addr[k+1];
      else       req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      n_assert++;
      if (rsp_rdata !== erd[k] || lat != int'(LAT)) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: rdata=%h lat=%0d want %h lat=%0d", k, rsp_rdata, lat, erd[k], LAT);
      end
      if (k > 0) begin
        n_assert++;
        if (acc[k] - acc[k-1] != int'(LAT + 2)) begin
          n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d", k, acc[k] - acc[k-1], LAT + 2);
        end
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic        err, eerr, we, half;
    int          lat;
    for (int i = 0; i < 80; i++) begin
      we   = 1'($urandom);
      half = 1'($urandom);
      addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 4) == 0) addr = addr | (32'h1 << $urandom_range(ADDR_W + 2, 31));
      wd   = $urandom;
      model(we, half, addr, wd, erd, eerr);
      send(we, half, addr, wd, int'($urandom_range(0, 3)), rd, err, lat);
      n_assert++;
      if (rd !== erd || err !== eerr || lat != int'(LAT)) begin
        n_fail++;
        $display("FAIL random[%0d] we=%0b half=%0b addr=%h: rdata=%h err=%0b lat=%0d want %h %0b %0d",
                 i, we, half, addr, rd, err, lat, erd, eerr, LAT);
      end
    end
  endtask

  initial begin
    #(PERIOD * 50000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_word();
    test_halfword();
    test_backpressure();
    test_reset_mid();
    test_range();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory responder: the memory-side end of the datapath's load/store interface.
- Replaces the zero-latency data memory when the core is moved to a stall-capable pipeline.
- Accepts one word or halfword load/store request at a time, inserts a programmable number of wait states, then returns a response.
- Holds the response until the requester accepts it.

Parameters:
- ADDR_W, 8, word-address width; storage depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request accept to rsp_valid; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_half  input  1  1 = halfword access, 0 = word access.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; for halfword stores only bits [15:0] are used.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores.
- rsp_err  output  1  access error; qualified by rsp_valid.

Behaviour:
- Reset (reset low, async): state IDLE, wait counter 0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture we, half, addr and wdata; load counter with LATENCY-1; go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle.
  - When the counter reaches 0, perform the access (commit point) and go to RESP.
  - rsp_valid rises exactly LATENCY cycles after the accept edge.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE; rsp_valid falls the next cycle.
  - req_ready stays 0 in RESP, so there is no request/response overlap; the minimum request-to-request spacing is LATENCY+2 cycles.
- Address map:
  - Word index = addr[ADDR_W+1:2].
  - Word access ignores addr[1:0].
  - Halfword select = addr[1]: 0 selects bits [15:0], 1 selects bits [31:16]. addr[0] is ignored.
- Load data:
  - Word load returns the full word.
  - Halfword load returns the selected halfword in [15:0], zero-extended; sign extension is the datapath's job.
- Store:
  - Word store writes all 32 bits.
  - Halfword store writes wdata[15:0] into the selected half; the other half is unchanged.
  - Response has rsp_rdata=0.
- Captured request fields are registered at accept, so later changes on req_* inputs have no effect on an access in flight.
- Reset mid-operation: return to IDLE immediately.
  - A store not yet at its commit point is dropped; memory is unchanged.
  - A store already committed is kept.
  - Any pending response is discarded.
- rsp_ready high while not in RESP: ignored.

Optional Feature:
- Macro DMEM_RANGE_CHECK_EN.
- Defined:
  - Any set bit in req_addr[31:ADDR_W+2] makes the access out of range.
  - Out-of-range store does not modify memory.
  - Out-of-range load returns 0.
  - Response carries rsp_err=1 with normal latency.
- Undefined:
  - Upper address bits are ignored (address wraps modulo depth).
  - rsp_err is tied to 0.

Test Plan:
1. Word store/load: store 0xDEADBEEF to addr 0x10, then load addr 0x10, LATENCY=2 → rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF; store response rdata=0.
2. Halfword merge: word 0x11223344 at 0x20; half store 0xABCD to 0x22; word load 0x20 → 0xABCD3344. Half load 0x20 → 0x00003344; half load 0x22 → 0x0000ABCD.
3. Response backpressure: load with rsp_ready held low 5 cycles → rsp_valid and rsp_rdata stable the whole time; req_ready=0 throughout; a req_valid raised meanwhile is not accepted until the cycle after rsp_ready is seen.
4. Reset mid-store: accept store 0x55 to 0x30 with LATENCY=4; assert reset after 2 cycles → outputs at reset values immediately. A later load of 0x30 returns the prior contents, not 0x55.
5. Range check: with DMEM_RANGE_CHECK_EN and ADDR_W=8, store to 0x400 → rsp_err=1 and memory word 0 is unchanged. Without the macro → the store lands at word 0 and rsp_err=0.
6. Back-to-back with rsp_ready held high: 3 loads, LATENCY=1 → each response 1 cycle after accept; accepts spaced exactly 3 cycles apart.
